// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared encodings and defaults for the memory arbiter
package arb_pkg;

   typedef enum logic {
      NORMAL = 1'b0,
      BURST  = 1'b1
   } arb_state_t;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DMA  = 2'd2
   } arb_owner_t;

   localparam int ARB_STARVE_MAX = 4;
   localparam int ARB_BURST_MAX  = 8;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter between the core and a DMA/debug port
module mem_arbiter
   import arb_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int STARVE_MAX = ARB_STARVE_MAX,
   parameter int BURST_MAX  = ARB_BURST_MAX
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_adr,
   input  logic [DW-1:0] cpu_wd,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic          dma_lock,
   input  logic [AW-1:0] dma_adr,
   input  logic [DW-1:0] dma_wd,
   output logic          dma_gnt,
   output logic [AW-1:0] mem_adr,
   output logic [DW-1:0] mem_wd,
   output logic          mem_we,
   output logic [DW-1:0] rd,
   input  logic [DW-1:0] mem_rd
);

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
   localparam logic [4:0] BEAT_LAST  = 5'(BURST_MAX - 1);
   localparam bit         BURST_EN   = (BURST_MAX > 1);

   arb_state_t state, state_next;
   arb_owner_t owner;
   logic [3:0] starve_cnt, starve_next;
   logic [4:0] beat_cnt, beat_next;
   logic       cpu_gnt;

   // Pick this cycle's owner; reset blocks both requesters outright
   always_comb begin
      owner = OWN_NONE;
      if (!reset) begin
         if (state == BURST) begin
            if (dma_req) owner = OWN_DMA;
         end else if (cpu_req && dma_req) begin
            owner = (starve_cnt < STARVE_LIM) ? OWN_CPU : OWN_DMA;
         end else if (cpu_req) begin
            owner = OWN_CPU;
         end else if (dma_req) begin
            owner = OWN_DMA;
         end
      end
   end

   assign cpu_gnt   = (owner == OWN_CPU);
   assign dma_gnt   = (owner == OWN_DMA);
   assign cpu_stall = cpu_req & ~cpu_gnt;
   assign rd        = mem_rd;

   // Route the winner onto the memory port; idle port drives zeros
   always_comb begin
      mem_adr = '0;
      mem_wd  = '0;
      mem_we  = 1'b0;
      case (owner)
         OWN_CPU: begin
            mem_adr = cpu_adr;
            mem_wd  = cpu_wd;
            mem_we  = cpu_we;
         end
         OWN_DMA: begin
            mem_adr = dma_adr;
            mem_wd  = dma_wd;
            mem_we  = dma_we;
         end
         default: ;
      endcase
   end

   // Burst FSM and fairness counter next-state
   always_comb begin
      state_next  = state;
      beat_next   = beat_cnt;
      starve_next = starve_cnt;
      case (state)
         NORMAL: begin
            if (dma_gnt && dma_lock && BURST_EN) begin
               state_next = BURST;
               beat_next  = 5'd1;
            end
         end
         BURST: begin
            // A dropped request ends the burst as well as a released lock or the last beat
            if (!dma_req || !dma_lock || (beat_cnt == BEAT_LAST)) begin
               state_next = NORMAL;
               beat_next  = '0;
            end else begin
               beat_next = beat_cnt + 5'd1;
            end
         end
         default: begin
            state_next = NORMAL;
            beat_next  = '0;
         end
      endcase
      if (dma_gnt || !dma_req) begin
         starve_next = '0;
      end else if (cpu_gnt && (starve_cnt < STARVE_LIM)) begin
         starve_next = starve_cnt + 4'd1;
      end
   end

   // State and counter registers; reset aborts any burst in flight
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= NORMAL;
         starve_cnt <= '0;
         beat_cnt   <= '0;
      end else begin
         state      <= state_next;
         starve_cnt <= starve_next;
         beat_cnt   <= beat_next;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized and directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

   localparam int AW         = 32;
   localparam int DW         = 32;
   localparam int STARVE_MAX = 4;
   localparam int BURST_MAX  = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req, cpu_we, dma_req, dma_we, dma_lock;
   logic [AW-1:0] cpu_adr, dma_adr;
   logic [DW-1:0] cpu_wd, dma_wd;
   logic          cpu_stall, dma_gnt, mem_we;
   logic [AW-1:0] mem_adr;
   logic [DW-1:0] mem_wd, rd, mem_rd;

   int checks   = 0;
   int failures = 0;

   // model state: beats already taken in the current locked burst, CPU wins while DMA waited
   int burst_beats = 0;
   int cpu_wins    = 0;
   logic e_cpu, e_dma;

   always #5 clk = ~clk;

   // memory read data is a fixed function of the address
   assign mem_rd = ~mem_adr;

   mem_arbiter #(
      .AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX), .BURST_MAX(BURST_MAX)
   ) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_adr(cpu_adr), .cpu_wd(cpu_wd),
      .cpu_stall(cpu_stall),
      .dma_req(dma_req), .dma_we(dma_we), .dma_lock(dma_lock),
      .dma_adr(dma_adr), .dma_wd(dma_wd), .dma_gnt(dma_gnt),
      .mem_adr(mem_adr), .mem_wd(mem_wd), .mem_we(mem_we),
      .rd(rd), .mem_rd(mem_rd)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // settle after inputs change, predict grants from the rules and compare every output
   task automatic settle();
      logic [AW-1:0] e_adr;
      logic [DW-1:0] e_wd;
      logic          e_we;
      #1;
      if (reset) begin
         burst_beats = 0;
         cpu_wins    = 0;
         e_cpu = 1'b0;
         e_dma = 1'b0;
      end else if (burst_beats > 0) begin
         e_cpu = 1'b0;
         e_dma = dma_req;
      end else if (cpu_req && dma_req) begin
         e_dma = (cpu_wins >= STARVE_MAX);
         e_cpu = !e_dma;
      end else begin
         e_cpu = cpu_req;
         e_dma = dma_req;
      end
      e_adr = e_cpu ? cpu_adr : (e_dma ? dma_adr : '0);
      e_wd  = e_cpu ? cpu_wd  : (e_dma ? dma_wd  : '0);
      e_we  = e_cpu ? cpu_we  : (e_dma ? dma_we  : 1'b0);
      check("cpu_stall", 32'(cpu_stall), 32'(cpu_req & ~e_cpu));
      check("dma_gnt",   32'(dma_gnt),   32'(e_dma));
      check("mem_we",    32'(mem_we),    32'(e_we));
      check("mem_adr",   mem_adr,        e_adr);
      check("mem_wd",    mem_wd,         e_wd);
      check("rd",        rd,             ~e_adr);
   endtask

   // clock edge: advance the model, then return to the falling edge for the next drive
   task automatic advance();
      @(posedge clk);
      if (reset) begin
         burst_beats = 0;
         cpu_wins    = 0;
      end else begin
         if (e_dma) burst_beats = (dma_lock && (burst_beats + 1 < BURST_MAX)) ? burst_beats + 1 : 0;
         else if (burst_beats > 0) burst_beats = 0;
         if (e_dma || !dma_req) cpu_wins = 0;
         else if (e_cpu && cpu_wins < STARVE_MAX) cpu_wins++;
      end
      @(negedge clk);
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [31:0] ca,
                        input logic dr, input logic dw, input logic dl, input logic [31:0] da);
      cpu_req = cr; cpu_we = cw; cpu_adr = ca; cpu_wd = ca ^ 32'h0F0F_0F0F;
      dma_req = dr; dma_we = dw; dma_lock = dl; dma_adr = da; dma_wd = da ^ 32'h3C3C_3C3C;
   endtask

   initial begin
      int first, cnt, scnt;
      reset = 1'b1;
      drive(1'b1, 1'b1, 32'h20, 1'b1, 1'b1, 1'b1, 32'h30);
      @(negedge clk);

      // reset holds both grants off and stalls the CPU
      settle();
      check("reset_stall", 32'(cpu_stall), 32'd1);
      advance();
      reset = 1'b0;

      // CPU-only read
      drive(1'b1, 1'b0, 32'h10, 1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      check("cpu_only_adr", mem_adr, 32'h10);
      check("cpu_only_rd", rd, ~32'h10);
      advance();

      // starvation bound: DMA wins on the fifth contested cycle
      first = -1; cnt = 0;
      for (int i = 0; i < 9; i++) begin
         drive(1'b1, 1'b0, 32'h100 + i, 1'b1, 1'b0, 1'b0, 32'h200 + i);
         settle();
         if (dma_gnt) begin
            cnt++;
            if (first < 0) first = i;
         end
         advance();
      end
      check("starve_first_dma", first, 4);
      check("starve_dma_count", cnt, 1);

      // full burst with CPU requesting throughout; DMA owns the slot via the fairness bound
      cnt = 0; scnt = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1'b1, 1'b0, 32'h300, 1'b1, 1'b0, 1'b1, 32'h400 + 4 * i);
         settle();
         if (dma_gnt) cnt++;
         if (cpu_stall) scnt++;
         if (i == 8) check("burst_cpu_after", 32'(cpu_stall), 32'd0);
         advance();
      end
      check("burst_dma_beats", cnt, BURST_MAX);
      check("burst_cpu_stalls", scnt, BURST_MAX);

      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      settle(); advance();

      // early exit: lock released on beat 3
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive(i > 0, 1'b0, 32'h500, 1'b1, 1'b0, i < 2, 32'h600 + 4 * i);
         settle();
         if (dma_gnt) cnt++;
         if (i == 3) check("early_cpu_gnt", 32'(cpu_stall), 32'd0);
         advance();
      end
      check("early_dma_beats", cnt, 3);

      // write routing: one DMA write then one CPU write
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h40);
      dma_wd = 32'hDEAD_BEEF;
      settle();
      check("dma_wr_we", 32'(mem_we), 32'd1);
      check("dma_wr_adr", mem_adr, 32'h40);
      check("dma_wr_wd", mem_wd, 32'hDEAD_BEEF);
      advance();
      drive(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      check("cpu_wr_we", 32'(mem_we), 32'd1);
      check("cpu_wr_adr", mem_adr, 32'h44);
      advance();
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      settle();
      check("idle_we", 32'(mem_we), 32'd0);
      advance();

      // reset in beat 2 of a burst aborts it
      drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h700);
      settle(); advance();
      drive(1'b1, 1'b0, 32'h80, 1'b1, 1'b1, 1'b1, 32'h704);
      reset = 1'b1;
      settle();
      check("rst_burst_gnt", 32'(dma_gnt), 32'd0);
      check("rst_burst_we", 32'(mem_we), 32'd0);
      advance();
      reset = 1'b0;
      settle();
      check("rst_cpu_gnt", 32'(cpu_stall), 32'd0);
      advance();

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         reset = ($urandom_range(0, 49) == 0);
         drive($urandom_range(0, 1), $urandom_range(0, 1), $urandom,
               $urandom_range(0, 3) != 0, $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom);
         settle();
         advance();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
